// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared widths, default timeout and controller state encoding
//               for the multiplier-sharing arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

   // Operand width presented to the shared multiplier
   localparam int DATA_W          = 4;
   // Product width returned by the shared multiplier
   localparam int RESULT_W        = 8;
   // WAIT cycles allowed before an operation is abandoned
   localparam int DEFAULT_TIMEOUT = 32;

   // Controller states; one operation is in flight at a time
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_A = 3'd1,
      ST_LOAD_B = 3'd2,
      ST_WAIT   = 3'd3,
      ST_RESP   = 3'd4
   } state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin selector. Picks the first active
//               request at or above the priority pointer, wrapping to the
//               lowest index when nothing above the pointer is requesting.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [ID_W-1:0]    o_idx,
   output logic               o_valid
);

   logic w_found;

   // Two fixed-order scans: upper segment (>= pointer) first, then wrap-around
   always_comb begin
      w_found = 1'b0;
      o_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_found && i_req[i] && (ID_W'(i) >= i_ptr)) begin
            w_found = 1'b1;
            o_idx   = ID_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_found && i_req[i]) begin
            w_found = 1'b1;
            o_idx   = ID_W'(i);
         end
      end
   end

   // One-hot form of the chosen index, empty when nobody requests
   always_comb begin
      o_grant = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         o_grant[i] = w_found && (o_idx == ID_W'(i));
      end
   end

   assign o_valid = w_found;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mult_arbiter
// Description : Shares one external sequential multiplier among NUM_REQ
//               requesters. Operands are captured on selection, streamed to
//               the multiplier as A then B, and the product (or a timeout
//               abort) is returned as a one-cycle tagged response.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_arbiter
   import mult_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*DATA_W-1:0]    req_a,
   input  logic [NUM_REQ*DATA_W-1:0]    req_b,
   output logic [NUM_REQ-1:0]           gnt,
   output logic                         rsp_valid,
   output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
   output logic [RESULT_W-1:0]          rsp_result,
   output logic                         rsp_err,
   output logic                         mult_start,
   output logic [DATA_W-1:0]            mult_data_in,
   input  logic [RESULT_W-1:0]          mult_result,
   input  logic                         mult_done
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t                r_state;
   logic [ID_W-1:0]       r_ptr;
   logic [ID_W-1:0]       r_id;
   logic [NUM_REQ-1:0]    r_gnt_oh;
   logic [DATA_W-1:0]     r_a;
   logic [DATA_W-1:0]     r_b;
   logic [CNT_W-1:0]      r_cnt;
   logic [RESULT_W-1:0]   r_result;
   logic                  r_err;

   logic [NUM_REQ-1:0]    w_arb_grant;
   logic [ID_W-1:0]       w_arb_idx;
   logic                  w_arb_valid;
   logic [DATA_W-1:0]     w_sel_a;
   logic [DATA_W-1:0]     w_sel_b;
   logic                  w_timeout;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_arbiter (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_grant (w_arb_grant),
      .o_idx   (w_arb_idx),
      .o_valid (w_arb_valid)
   );

   // Operand mux for the selected requester, constant-index slices only
   always_comb begin
      w_sel_a = '0;
      w_sel_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_arb_idx == ID_W'(i)) begin
            w_sel_a = req_a[i*DATA_W +: DATA_W];
            w_sel_b = req_b[i*DATA_W +: DATA_W];
         end
      end
   end

   // Last permitted WAIT cycle: a done here still wins over the abort
   assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

   // Controller: capture on selection, stream operands, await done or timeout
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_ptr    <= '0;
         r_id     <= '0;
         r_gnt_oh <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_arb_valid) begin
                  r_id     <= w_arb_idx;
                  r_gnt_oh <= w_arb_grant;
                  r_a      <= w_sel_a;
                  r_b      <= w_sel_b;
                  r_ptr    <= (w_arb_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                               : w_arb_idx + 1'b1;
                  r_state  <= ST_LOAD_A;
               end
            end
            ST_LOAD_A: begin
               r_state <= ST_LOAD_B;
            end
            ST_LOAD_B: begin
               r_cnt   <= '0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (mult_done) begin
                  r_result <= mult_result;
                  r_err    <= 1'b0;
                  r_state  <= ST_RESP;
               end else if (w_timeout) begin
                  r_result <= '0;
                  r_err    <= 1'b1;
                  r_state  <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Multiplier bus: A with start in LOAD_A, B in LOAD_B, quiet otherwise
   always_comb begin
      mult_start   = 1'b0;
      mult_data_in = '0;
      gnt          = '0;
      if (r_state == ST_LOAD_A) begin
         mult_start   = 1'b1;
         mult_data_in = r_a;
         gnt          = r_gnt_oh;
      end else if (r_state == ST_LOAD_B) begin
         mult_data_in = r_b;
      end
   end

   // Response fields are held at zero except during the response strobe
   always_comb begin
      rsp_valid  = (r_state == ST_RESP);
      rsp_id     = rsp_valid ? r_id     : '0;
      rsp_result = rsp_valid ? r_result : '0;
      rsp_err    = rsp_valid ? r_err    : 1'b0;
   end

endmodule : mult_arbiter
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_arbiter
// Description : Scoreboard bench for mult_arbiter with a behavioural model of
//               the shared multiplier whose done timing is set per vector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_arbiter;
   import mult_pkg::*;

   localparam int N = 4;

   logic             clock = 1'b0;
   logic             reset;
   logic [N-1:0]     req;
   logic [N*4-1:0]   req_a;
   logic [N*4-1:0]   req_b;
   logic [N-1:0]     gnt;
   logic             rsp_valid;
   logic [1:0]       rsp_id;
   logic [7:0]       rsp_result;
   logic             rsp_err;
   logic             mult_start;
   logic [3:0]       mult_data_in;
   logic [7:0]       mult_result;
   logic             mult_done;

   mult_arbiter #(.NUM_REQ(N), .TIMEOUT(32)) dut (
      .clock        (clock),
      .reset        (reset),
      .req          (req),
      .req_a        (req_a),
      .req_b        (req_b),
      .gnt          (gnt),
      .rsp_valid    (rsp_valid),
      .rsp_id       (rsp_id),
      .rsp_result   (rsp_result),
      .rsp_err      (rsp_err),
      .mult_start   (mult_start),
      .mult_data_in (mult_data_in),
      .mult_result  (mult_result),
      .mult_done    (mult_done)
   );

   always #5 clock = ~clock;

   typedef struct {
      int id;
      int res;
      int err;
   } rsp_t;

   rsp_t exp_rsp[$];
   int   exp_gnt[$];
   int   exp_opa[$];
   int   exp_opb[$];

   int errors     = 0;
   int checks     = 0;
   int cyc        = 0;
   int n_rsp      = 0;
   int rsp_cyc    = 0;
   int loadb_cyc  = 0;
   int done_delay = -1;
   bit early_done = 1'b0;

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic push_op(input int id, input int a, input int b,
                          input bit has_rsp, input int res, input int err);
      rsp_t e;
      exp_gnt.push_back(id);
      exp_opa.push_back(a);
      exp_opb.push_back(b);
      if (has_rsp) begin
         e.id  = id;
         e.res = res;
         e.err = err;
         exp_rsp.push_back(e);
      end
   endtask

   task automatic set_op(input int i, input int a, input int b);
      req_a[i*4 +: 4] = 4'(a);
      req_b[i*4 +: 4] = 4'(b);
   endtask

   task automatic pulse_req(input int mask);
      @(posedge clock); #1;
      req = N'(mask);
      @(posedge clock); #1;
      req = '0;
   endtask

   task automatic wait_rsp(input int target, input int budget);
      int n;
      n = 0;
      while (n_rsp < target && n < budget) begin
         @(negedge clock); #1;
         n++;
      end
      if (n_rsp < target) begin
         checks++;
         errors++;
         $display("FAIL wait_rsp: got %0d responses expected %0d", n_rsp, target);
      end
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   // Response and grant monitor
   always @(negedge clock) begin
      rsp_t e;
      int   g;
      if (rsp_valid) begin
         rsp_cyc = cyc;
         n_rsp++;
         if (exp_rsp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got id %0d result %0d err %0d expected none",
                     rsp_id, rsp_result, rsp_err);
         end else begin
            e = exp_rsp.pop_front();
            check("rsp_id", int'(rsp_id), e.id);
            check("rsp_result", int'(rsp_result), e.res);
            check("rsp_err", int'(rsp_err), e.err);
         end
      end
      if (gnt != '0) begin
         if (exp_gnt.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL gnt_unexpected: got %0d expected none", gnt);
         end else begin
            g = exp_gnt.pop_front();
            check("gnt", int'(gnt), 1 << g);
            check("gnt_with_start", int'(mult_start), 1);
         end
      end
   end

   // Shared multiplier model: A with start, B next cycle, done after done_delay
   initial begin
      int ma;
      int mb;
      mult_done   = 1'b0;
      mult_result = '0;
      forever begin
         @(negedge clock);
         if (mult_start && !reset) begin
            ma = int'(mult_data_in);
            @(posedge clock); #1;
            if (early_done) begin
               mult_done   = 1'b1;
               mult_result = 8'hEE;
            end
            @(negedge clock);
            mb        = int'(mult_data_in);
            loadb_cyc = cyc;
            if (exp_opa.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL operand_unexpected: got a %0d b %0d expected none", ma, mb);
            end else begin
               check("op_a", ma, exp_opa.pop_front());
               check("op_b", mb, exp_opb.pop_front());
            end
            @(posedge clock); #1;
            mult_done   = 1'b0;
            mult_result = '0;
            if (done_delay >= 1) begin
               repeat (done_delay - 1) @(posedge clock);
               #1;
               mult_done   = 1'b1;
               mult_result = 8'(ma * mb);
               @(posedge clock); #1;
               mult_done   = 1'b0;
               mult_result = '0;
            end
         end
      end
   end

   // Watchdog against a stuck run
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   // Directed vectors
   initial begin
      reset = 1'b1;
      req   = '0;
      req_a = '0;
      req_b = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset_outputs", int'({gnt, rsp_valid, rsp_id, rsp_result, rsp_err,
                                   mult_start, mult_data_in}), 0);
      @(posedge clock); #1;
      reset = 1'b0;

      // Single request 3*5, done 4 cycles after LOAD_B
      set_op(0, 3, 5);
      done_delay = 4;
      push_op(0, 3, 5, 1'b1, 15, 0);
      pulse_req(4'b0001);
      wait_rsp(1, 50);
      check("lat_single", rsp_cyc - loadb_cyc, 5);

      // Contention after reset: order 0,1,2,3,0
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      for (int i = 0; i < N; i++) set_op(i, i + 1, i + 2);
      done_delay = 1;
      push_op(0, 1, 2, 1'b1, 2, 0);
      push_op(1, 2, 3, 1'b1, 6, 0);
      push_op(2, 3, 4, 1'b1, 12, 0);
      push_op(3, 4, 5, 1'b1, 20, 0);
      push_op(0, 1, 2, 1'b1, 2, 0);
      @(posedge clock); #1;
      req = 4'b1111;
      wait_rsp(6, 100);
      req = '0;
      check("lat_fast", rsp_cyc - loadb_cyc, 2);

      // Timeout with no done
      set_op(2, 7, 9);
      done_delay = -1;
      push_op(2, 7, 9, 1'b1, 0, 1);
      pulse_req(4'b0100);
      wait_rsp(7, 100);
      check("lat_timeout", rsp_cyc - loadb_cyc, 33);

      // Done on the final WAIT cycle wins over the timeout
      set_op(1, 6, 7);
      done_delay = 32;
      push_op(1, 6, 7, 1'b1, 42, 0);
      pulse_req(4'b0010);
      wait_rsp(8, 100);
      check("lat_coincident", rsp_cyc - loadb_cyc, 33);

      // Done during LOAD_B is ignored; the later done completes the op
      set_op(3, 4, 5);
      early_done = 1'b1;
      done_delay = 3;
      push_op(3, 4, 5, 1'b1, 20, 0);
      pulse_req(4'b1000);
      wait_rsp(9, 50);
      early_done = 1'b0;
      check("lat_early_done", rsp_cyc - loadb_cyc, 4);

      // Max operands, changed right after capture
      set_op(0, 15, 15);
      done_delay = 2;
      push_op(0, 15, 15, 1'b1, 225, 0);
      @(posedge clock); #1;
      req = 4'b0001;
      @(posedge clock); #1;
      req = '0;
      set_op(0, 1, 1);
      wait_rsp(10, 50);

      // Reset mid-WAIT aborts silently and clears the pointer
      set_op(2, 5, 5);
      done_delay = -1;
      push_op(2, 5, 5, 1'b0, 0, 0);
      pulse_req(4'b0100);
      repeat (8) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("reset_mid_outputs", int'({gnt, rsp_valid, rsp_id, rsp_result, rsp_err,
                                       mult_start, mult_data_in}), 0);
      @(posedge clock); #1;
      reset = 1'b0;
      repeat (40) @(posedge clock);
      #1;
      check("abort_no_rsp", n_rsp, 10);
      set_op(1, 2, 3);
      set_op(3, 9, 9);
      done_delay = 1;
      push_op(1, 2, 3, 1'b1, 6, 0);
      @(posedge clock); #1;
      req = 4'b1010;
      wait_rsp(11, 50);
      req = '0;

      repeat (6) @(posedge clock);
      check("rsp_left", exp_rsp.size(), 0);
      check("gnt_left", exp_gnt.size(), 0);
      check("ops_left", exp_opa.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_mult_arbiter
`default_nettype wire

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clock and reset ports SHALL be named clock and reset.
REQ-002 The block SHALL provide parameter NUM_REQ, default 4, meaning the number of requesters (2..8).
REQ-003 The block SHALL provide parameter TIMEOUT, default 32, meaning the maximum WAIT cycles before abort.
REQ-004 The block SHALL provide the following ports, one per line as name, direction, width, meaning:
  clock         input   1            system clock, rising edge
  reset         input   1            synchronous, active-high
  req           input   NUM_REQ      per-requester request, level
  req_a         input   NUM_REQ x 4  per-requester multiplicand
  req_b         input   NUM_REQ x 4  per-requester multiplier
  gnt           output  NUM_REQ      one-hot, one-cycle operand-capture pulse
  rsp_valid     output  1            one-cycle response strobe
  rsp_id        output  log2(NUM_REQ) requester index of the response
  rsp_result    output  8            product
  rsp_err       output  1            response aborted by timeout
  mult_start    output  1            multiplier start
  mult_data_in  output  4            multiplier operand bus
  mult_result   input   8            multiplier product
  mult_done     input   1            multiplier completion pulse

Function
REQ-005 The multiplier protocol SHALL be: mult_start high for one cycle with mult_data_in = A, the next cycle mult_data_in = B, and mult_done high for one cycle with mult_result valid.
REQ-006 The FSM SHALL have the states IDLE, LOAD_A, LOAD_B, WAIT and RESP.
REQ-007 In IDLE with any req bit high, the block SHALL select the winner by round-robin from the priority pointer, register its id, A and B, and enter LOAD_A next cycle; with no req it SHALL stay in IDLE.
REQ-008 In LOAD_A: mult_start=1, mult_data_in=captured A, gnt[id]=1; next state LOAD_B.
REQ-009 In LOAD_B: mult_start=0, mult_data_in=captured B; next state WAIT; the wait counter SHALL clear.
REQ-010 In WAIT: the counter SHALL increment each cycle; on mult_done, the block SHALL capture mult_result and enter RESP with err=0.
REQ-011 In WAIT, if the counter reaches TIMEOUT without mult_done, the block SHALL enter RESP with err=1 and result 0.
REQ-012 If mult_done and the timeout coincide, mult_done SHALL win (err=0).
REQ-013 In RESP: rsp_valid=1, with rsp_id, rsp_result and rsp_err driven from registers; next state IDLE; latency from mult_done to rsp_valid SHALL be exactly 1 cycle.
REQ-014 The block SHALL ignore mult_done outside WAIT.
REQ-015 Priority pointer SHALL update on grant to (id+1) mod NUM_REQ; a requester SHALL never wait more than NUM_REQ-1 other grants.
REQ-016 Operands SHALL be sampled only in the IDLE->LOAD_A transition; later changes on req_a/req_b or req SHALL not affect the operation in flight.
REQ-017 A requester still asserting req after its response SHALL be treated as a new request.
REQ-018 Minimum request-to-response time SHALL be 5 cycles (IDLE, LOAD_A, LOAD_B, WAIT with immediate done, RESP); one operation SHALL be in flight at a time.
REQ-019 Outside the states in REQ-008..REQ-013, mult_start, gnt and rsp_valid SHALL be 0, and mult_data_in SHALL be 0 in IDLE, WAIT and RESP.

Reset
REQ-020 On reset, the state SHALL be IDLE, the priority pointer 0, and the counter 0.
REQ-021 On reset, all outputs SHALL be 0, including gnt, rsp_*, mult_start and mult_data_in.
REQ-022 Reset asserted mid-operation SHALL abort without a response; the shared multiplier is reset on the same reset signal.

Structure
REQ-023 Package mult_pkg SHALL hold the state enum, DATA_W=4, RESULT_W=8 and the default TIMEOUT.
REQ-024 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req and pointer; outputs one-hot grant and index).

Verification
REQ-025 Single request: req[0], A=3, B=5, done 4 cycles after LOAD_B with result 15 -> gnt[0] in LOAD_A, rsp_id=0, rsp_result=15, rsp_err=0.
REQ-026 Contention: req=4'b1111 held after reset -> grant order 0,1,2,3,0.
REQ-027 Timeout: req[2], done never asserted -> rsp_valid exactly 32 cycles after entering WAIT, rsp_id=2, rsp_err=1, rsp_result=0.
REQ-028 Coincident events: done on the timeout cycle -> rsp_err=0; done during LOAD_B -> ignored, op waits for the next done.
REQ-029 Boundary: A=15, B=15 -> rsp_result=225; operands changed after gnt -> the multiplier sees the original values.
REQ-030 Reset mid-WAIT -> no rsp_valid, all outputs 0 the next cycle, and the next grant follows pointer 0.
